// File: rtl/emailbox_mc.sv
// rtl/emailbox_mc.sv - NCH independent 64-bit mailbox FIFOs filled by emesh writes, drained over mi
module emailbox_mc #(
    parameter int          PW    = 104,
    parameter int          RFAW  = 6,
    parameter logic [11:0] ID    = 12'h000,
    parameter logic [3:0]  GROUP = 4'hF,
    parameter int          NCH   = 4,
    parameter int          DEPTH = 16,
    parameter int          MBASE = 1
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            emesh_access,
    input  logic [PW-1:0]   emesh_packet,
    input  logic            mi_en,
    input  logic            mi_we,
    input  logic [RFAW+1:0] mi_addr,
    input  logic [31:0]     mi_din,
    output logic [31:0]     mi_dout,
    output logic [NCH-1:0]  mailbox_irq
);
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int HW   = RFAW - CW - 2;
    localparam logic [HW-1:0]   MB      = MBASE[HW-1:0];
    localparam logic [CW:0]     NCH_C   = NCH[CW:0];
    localparam logic [CNTW-1:0] FULLCNT = DEPTH[CNTW-1:0];

    logic        pkt_write;
    logic [31:0] dstaddr;
    logic [31:0] pkt_data;
    logic [31:0] srcaddr;

    assign pkt_write = emesh_packet[0];
    assign dstaddr   = emesh_packet[39:8];
    assign pkt_data  = emesh_packet[71:40];
    assign srcaddr   = emesh_packet[103:72];

    logic [CW-1:0] e_ch, m_ch;
    logic [1:0]    e_reg, m_reg;
    logic          e_sel, m_sel;
    logic          push_req, mi_rd, mi_wr, pop_req;

    assign e_ch  = dstaddr[CW+3:4];
    assign e_reg = dstaddr[3:2];
    assign e_sel = (dstaddr[RFAW+1:CW+4] == MB) && ({1'b0, e_ch} < NCH_C);
    assign m_ch  = mi_addr[CW+3:4];
    assign m_reg = mi_addr[3:2];
    assign m_sel = (mi_addr[RFAW+1:CW+4] == MB) && ({1'b0, m_ch} < NCH_C);

    assign push_req = emesh_access && pkt_write && (dstaddr[31:20] == ID) &&
                      (dstaddr[19:16] == GROUP) && e_sel && (e_reg == 2'd0);
    assign mi_rd    = mi_en && !mi_we && m_sel;
    assign mi_wr    = mi_en && mi_we && m_sel;
    assign pop_req  = mi_rd && (m_reg == 2'd1);

    logic [CNTW-1:0] count_q [NCH];
    logic [CNTW-1:0] count_d [NCH];
    logic [AW-1:0]   wptr_q  [NCH];
    logic [AW-1:0]   wptr_d  [NCH];
    logic [AW-1:0]   rptr_q  [NCH];
    logic [AW-1:0]   rptr_d  [NCH];
    logic [7:0]      thresh_q [NCH];
    logic [7:0]      thresh_d [NCH];
    logic [NCH-1:0]  ovf_q, ovf_d;
    logic [NCH-1:0]  irq_en_q, irq_en_d;
    logic [NCH-1:0]  irq_q, irq_d;
    logic [31:0]     mi_dout_q, mi_dout_d;

    logic [63:0]     mem [NCH][DEPTH];

    logic [NCH-1:0]  ch_push, ch_pop, ch_acc, ch_ovf_ev, ch_full, ch_ne;

    // A pop on a full channel frees the slot the same-cycle push lands in.
    always_comb begin
        ch_push   = '0;
        ch_pop    = '0;
        ch_acc    = '0;
        ch_ovf_ev = '0;
        ch_full   = '0;
        ch_ne     = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_full[i]   = (count_q[i] == FULLCNT);
            ch_ne[i]     = (count_q[i] != '0);
            ch_push[i]   = push_req && (e_ch == CW'(i));
            ch_pop[i]    = pop_req && (m_ch == CW'(i)) && ch_ne[i];
            ch_acc[i]    = ch_push[i] && (!ch_full[i] || ch_pop[i]);
            ch_ovf_ev[i] = ch_push[i] && ch_full[i] && !ch_pop[i];
        end
    end

    always_comb begin
        ovf_d    = ovf_q;
        irq_en_d = irq_en_q;
        irq_d    = '0;
        for (int i = 0; i < NCH; i++) begin
            count_d[i]  = count_q[i];
            wptr_d[i]   = wptr_q[i];
            rptr_d[i]   = rptr_q[i];
            thresh_d[i] = thresh_q[i];
            case ({ch_acc[i], ch_pop[i]})
                2'b10:   count_d[i] = count_q[i] + CNTW'(1);
                2'b01:   count_d[i] = count_q[i] - CNTW'(1);
                default: count_d[i] = count_q[i];
            endcase
            if (ch_acc[i]) wptr_d[i] = wptr_q[i] + AW'(1);
            if (ch_pop[i]) rptr_d[i] = rptr_q[i] + AW'(1);
            if (ch_ovf_ev[i]) begin
                ovf_d[i] = 1'b1;
            end else if (mi_wr && (m_ch == CW'(i)) && (m_reg == 2'd2) && mi_din[2]) begin
                ovf_d[i] = 1'b0;
            end
            if (mi_wr && (m_ch == CW'(i)) && (m_reg == 2'd3)) begin
                irq_en_d[i] = mi_din[0];
                thresh_d[i] = mi_din[15:8];
            end
            irq_d[i] = irq_en_q[i] &&
                       ((16'(count_q[i]) >= ((thresh_q[i] == 8'd0) ? 16'd1 : 16'(thresh_q[i]))) ||
                        ovf_q[i]);
        end
    end

    logic [63:0] head;
    logic [15:0] cnt_ext;
    logic [31:0] rdata;

    always_comb begin
        head    = mem[m_ch][rptr_q[m_ch]];
        cnt_ext = 16'(count_q[m_ch]);
        rdata   = '0;
        case (m_reg)
            2'd0:    if (ch_ne[m_ch]) rdata = head[31:0];
            2'd1:    if (ch_ne[m_ch]) rdata = head[63:32];
            2'd2:    rdata = {16'b0, cnt_ext[7:0], 5'b0, ovf_q[m_ch], ch_full[m_ch], ch_ne[m_ch]};
            default: rdata = {16'b0, thresh_q[m_ch], 7'b0, irq_en_q[m_ch]};
        endcase
        mi_dout_d = mi_rd ? rdata : 32'b0;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < NCH; i++) begin
                count_q[i]  <= '0;
                wptr_q[i]   <= '0;
                rptr_q[i]   <= '0;
                thresh_q[i] <= '0;
            end
            ovf_q     <= '0;
            irq_en_q  <= '0;
            irq_q     <= '0;
            mi_dout_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                count_q[i]  <= count_d[i];
                wptr_q[i]   <= wptr_d[i];
                rptr_q[i]   <= rptr_d[i];
                thresh_q[i] <= thresh_d[i];
            end
            ovf_q     <= ovf_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
            mi_dout_q <= mi_dout_d;
        end
    end

    // Storage is not reset; empty-channel reads are masked by the count instead.
    always_ff @(posedge clk) begin
        if (|ch_acc) mem[e_ch][wptr_q[e_ch]] <= {srcaddr, pkt_data};
    end

    assign mi_dout     = mi_dout_q;
    assign mailbox_irq = irq_q;

    logic unused_bits;
    assign unused_bits = ^{emesh_packet[7:1], dstaddr[15:RFAW+2], dstaddr[1:0], mi_addr[1:0],
                           mi_din[31:16], mi_din[7:3], mi_din[1]};
endmodule

// File: tb/tb_emailbox_mc.sv
// tb/tb_emailbox_mc.sv - directed table-driven bench for emailbox_mc
module tb_emailbox_mc;
    localparam logic [11:0] ID  = 12'h000;
    localparam logic [3:0]  GRP = 4'hF;

    logic         clk = 1'b0;
    logic         nreset;
    logic         emesh_access;
    logic [103:0] emesh_packet;
    logic         mi_en;
    logic         mi_we;
    logic [7:0]   mi_addr;
    logic [31:0]  mi_din;
    logic [31:0]  mi_dout;
    logic [3:0]   mailbox_irq;

    always #5 clk = ~clk;

    emailbox_mc #(.PW(104), .RFAW(6), .ID(ID), .GROUP(GRP), .NCH(4), .DEPTH(16), .MBASE(1)) dut (
        .clk(clk), .nreset(nreset), .emesh_access(emesh_access), .emesh_packet(emesh_packet),
        .mi_en(mi_en), .mi_we(mi_we), .mi_addr(mi_addr), .mi_din(mi_din),
        .mi_dout(mi_dout), .mailbox_irq(mailbox_irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [103:0] mkpkt(input logic [1:0] ch, input logic [31:0] data,
                                           input logic [31:0] src, input logic [11:0] id,
                                           input logic [3:0] grp);
        logic [31:0] dst;
        dst = {id, grp, 8'h00, 2'b01, ch, 2'b00, 2'b00};
        return {src, data, dst, 5'b0, 2'b10, 1'b1};
    endfunction

    // One cycle: optional emesh push and optional mi access, returns at the next negedge.
    task automatic step(input logic do_push, input logic [1:0] pch, input logic [31:0] pdata,
                        input logic [31:0] psrc, input logic [11:0] pid, input logic [3:0] pgrp,
                        input logic do_mi, input logic we, input logic [1:0] mch,
                        input logic [1:0] mreg, input logic [31:0] din);
        emesh_access = do_push;
        emesh_packet = mkpkt(pch, pdata, psrc, pid, pgrp);
        mi_en        = do_mi;
        mi_we        = we;
        mi_addr      = {2'b01, mch, mreg, 2'b00};
        mi_din       = din;
        @(negedge clk);
        emesh_access = 1'b0;
        mi_en        = 1'b0;
    endtask

    task automatic push(input logic [1:0] ch, input logic [31:0] data, input logic [31:0] src);
        step(1'b1, ch, data, src, ID, GRP, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
    endtask

    task automatic rd(input logic [1:0] ch, input logic [1:0] rg);
        step(1'b0, 2'd0, 32'h0, 32'h0, ID, GRP, 1'b1, 1'b0, ch, rg, 32'h0);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [1:0] rg, input logic [31:0] din);
        step(1'b0, 2'd0, 32'h0, 32'h0, ID, GRP, 1'b1, 1'b1, ch, rg, din);
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 32'h0, 32'h0, ID, GRP, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
    endtask

    typedef struct {
        int          kind;      // 0 push, 1 mi read, 2 mi write
        logic [1:0]  ch;
        logic [1:0]  rg;
        logic [31:0] data;
        logic [31:0] src;
        logic [31:0] exp_dout;
        logic [3:0]  exp_irq;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1, 2'd0, 2'd2, 32'h0,        32'h0,        32'h0,        4'h0};
        vecs[1]  = '{0, 2'd2, 2'd0, 32'hDEADBEEF, 32'h12345678, 32'h0,        4'h0};
        vecs[2]  = '{1, 2'd2, 2'd0, 32'h0,        32'h0,        32'hDEADBEEF, 4'h0};
        vecs[3]  = '{1, 2'd2, 2'd1, 32'h0,        32'h0,        32'h12345678, 4'h0};
        vecs[4]  = '{1, 2'd2, 2'd2, 32'h0,        32'h0,        32'h00000000, 4'h0};
        vecs[5]  = '{2, 2'd1, 2'd3, 32'h00000301, 32'h0,        32'h0,        4'h0};
        vecs[6]  = '{1, 2'd1, 2'd3, 32'h0,        32'h0,        32'h00000301, 4'h0};
        vecs[7]  = '{0, 2'd1, 2'd0, 32'h000000A1, 32'h000000B1, 32'h0,        4'h0};
        vecs[8]  = '{0, 2'd1, 2'd0, 32'h000000A2, 32'h000000B2, 32'h0,        4'h0};
        vecs[9]  = '{0, 2'd1, 2'd0, 32'h000000A3, 32'h000000B3, 32'h0,        4'h0};
        vecs[10] = '{1, 2'd1, 2'd2, 32'h0,        32'h0,        32'h00000301, 4'h2};
        vecs[11] = '{1, 2'd1, 2'd1, 32'h0,        32'h0,        32'h000000B1, 4'h2};
        vecs[12] = '{1, 2'd1, 2'd0, 32'h0,        32'h0,        32'h000000A2, 4'h0};
        vecs[13] = '{1, 2'd1, 2'd2, 32'h0,        32'h0,        32'h00000201, 4'h0};

        nreset       = 1'b0;
        emesh_access = 1'b0;
        emesh_packet = '0;
        mi_en        = 1'b0;
        mi_we        = 1'b0;
        mi_addr      = '0;
        mi_din       = '0;
        repeat (2) @(negedge clk);
        check("reset irq", {28'b0, mailbox_irq}, 32'h0);
        check("reset dout", mi_dout, 32'h0);
        nreset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            case (vecs[i].kind)
                0:       push(vecs[i].ch, vecs[i].data, vecs[i].src);
                1:       rd(vecs[i].ch, vecs[i].rg);
                default: wr(vecs[i].ch, vecs[i].rg, vecs[i].data);
            endcase
            if (vecs[i].kind == 1) check($sformatf("vec%0d dout", i), mi_dout, vecs[i].exp_dout);
            check($sformatf("vec%0d irq", i), {28'b0, mailbox_irq}, {28'b0, vecs[i].exp_irq});
        end
        idle();
        check("dout after idle", mi_dout, 32'h0);

        // ch0 overflow, overflow-vs-W1C priority, then clear
        for (int i = 0; i < 16; i++) push(2'd0, 32'h100 + i, 32'h200 + i);
        rd(2'd0, 2'd2);
        check("ch0 full stat", mi_dout, 32'h00001003);
        push(2'd0, 32'h1FF, 32'h2FF);
        rd(2'd0, 2'd2);
        check("ch0 ovf stat", mi_dout, 32'h00001007);
        step(1'b1, 2'd0, 32'h1FE, 32'h2FE, ID, GRP, 1'b1, 1'b1, 2'd0, 2'd2, 32'h4);
        rd(2'd0, 2'd2);
        check("ovf beats w1c", mi_dout, 32'h00001007);
        wr(2'd0, 2'd2, 32'h4);
        rd(2'd0, 2'd2);
        check("ovf cleared", mi_dout, 32'h00001003);
        rd(2'd0, 2'd0);
        check("ch0 head kept", mi_dout, 32'h00000100);

        // ch3 full with same-cycle push+pop across the pointer wrap
        for (int i = 0; i < 16; i++) push(2'd3, i, i);
        step(1'b1, 2'd3, 32'd16, 32'd16, ID, GRP, 1'b1, 1'b0, 2'd3, 2'd1, 32'h0);
        check("ch3 pushpop0", mi_dout, 32'd0);
        step(1'b1, 2'd3, 32'd17, 32'd17, ID, GRP, 1'b1, 1'b0, 2'd3, 2'd1, 32'h0);
        check("ch3 pushpop1", mi_dout, 32'd1);
        rd(2'd3, 2'd2);
        check("ch3 stat full no ovf", mi_dout, 32'h00001003);
        for (int i = 0; i < 16; i++) begin
            rd(2'd3, 2'd1);
            check($sformatf("ch3 drain%0d", i), mi_dout, 32'd2 + i);
        end
        rd(2'd3, 2'd2);
        check("ch3 stat empty", mi_dout, 32'h0);

        // reset mid-operation with a push in flight
        push(2'd1, 32'hA4, 32'hB4);
        idle();
        check("pre-reset irq", {28'b0, mailbox_irq}, 32'h2);
        emesh_access = 1'b1;
        emesh_packet = mkpkt(2'd2, 32'h55, 32'h66, ID, GRP);
        nreset       = 1'b0;
        @(negedge clk);
        check("irq in reset", {28'b0, mailbox_irq}, 32'h0);
        nreset       = 1'b1;
        emesh_access = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            rd(c[1:0], 2'd2);
            check($sformatf("post-reset stat ch%0d", c), mi_dout, 32'h0);
        end
        rd(2'd1, 2'd3);
        check("post-reset cfg ch1", mi_dout, 32'h0);
        rd(2'd0, 2'd1);
        check("empty hi read", mi_dout, 32'h0);
        rd(2'd0, 2'd2);
        check("empty count kept", mi_dout, 32'h0);
        check("post-reset irq", {28'b0, mailbox_irq}, 32'h0);

        // interleaved channels, filtered ID/GROUP
        push(2'd0, 32'h10, 32'h10);
        push(2'd1, 32'h20, 32'h20);
        push(2'd0, 32'h11, 32'h11);
        step(1'b1, 2'd1, 32'h21, 32'h21, ID, GRP, 1'b1, 1'b0, 2'd0, 2'd1, 32'h0);
        check("ilv pop ch0", mi_dout, 32'h10);
        step(1'b1, 2'd0, 32'h99, 32'h99, 12'h123, GRP, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
        step(1'b1, 2'd1, 32'h98, 32'h98, ID, 4'h3, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
        step(1'b1, 2'd0, 32'h12, 32'h12, ID, GRP, 1'b1, 1'b0, 2'd1, 2'd1, 32'h0);
        check("ilv pop ch1", mi_dout, 32'h20);
        rd(2'd0, 2'd2);
        check("ilv stat ch0", mi_dout, 32'h00000201);
        rd(2'd1, 2'd2);
        check("ilv stat ch1", mi_dout, 32'h00000101);
        rd(2'd0, 2'd1);
        check("ilv ch0 a", mi_dout, 32'h11);
        rd(2'd0, 2'd1);
        check("ilv ch0 b", mi_dout, 32'h12);
        rd(2'd1, 2'd1);
        check("ilv ch1 a", mi_dout, 32'h21);
        rd(2'd0, 2'd2);
        check("ilv ch0 empty", mi_dout, 32'h0);
        rd(2'd1, 2'd2);
        check("ilv ch1 empty", mi_dout, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
